l2_lookup_pipe: RTL and testbench

Parametrised, handshaked lookup stage for the Spandex L2. It resolves tag hit, empty way and victim way for one set's tag/state snapshot, and reports per-word state masks. It adds word-granularity request masks, an internal round-robin victim pointer and multi-hit detection. It sits between the set-read buffers and the L2 request/forward FSMs and replaces the single-cycle lookup with a one-deep registered pipeline stage using valid/ready.

---
 rtl/l2_lookup_pkg.sv | 22 ++
 rtl/l2_lookup_way_scan.sv | 32 +++
 rtl/l2_lookup_pipe.sv | 191 +++++++++++++++++++
 tb/tb_l2_lookup_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_lookup_pkg.sv
// Shared constants and types for the L2 lookup stage: request modes,
// per-word coherence state encodings, and default-geometry field types.
package l2_lookup_pkg;

  localparam logic L2_LOOKUP     = 1'b0;
  localparam logic L2_LOOKUP_FWD = 1'b1;

  localparam int L2_WAYS     = 8;
  localparam int L2_WORDS    = 4;
  localparam int L2_TAG_W    = 20;
  localparam int SPX_STATE_W = 3;

  // A word is valid when its state compares greater than SPX_I.
  localparam logic [SPX_STATE_W-1:0] SPX_I = 3'd0;
  localparam logic [SPX_STATE_W-1:0] SPX_S = 3'd1;
  localparam logic [SPX_STATE_W-1:0] SPX_R = 3'd2;

  typedef logic [$clog2(L2_WAYS)-1:0] l2_way_t;
  typedef logic [L2_WORDS-1:0]        word_mask_t;
  typedef logic [L2_TAG_W-1:0]        l2_tag_t;

endpackage

// File: rtl/l2_lookup_way_scan.sv
// Per-way scan of one set snapshot: flags ways holding any valid word and
// ways that are both present and carry the requested tag.
module l2_lookup_way_scan
  import l2_lookup_pkg::*;
#(
  parameter int WAYS    = 8,
  parameter int WORDS   = 4,
  parameter int TAG_W   = 20,
  parameter int STATE_W = 3
) (
  input  logic [TAG_W-1:0]               tag,
  input  logic [WAYS*TAG_W-1:0]          tags,
  input  logic [WAYS*WORDS*STATE_W-1:0]  states,
  output logic [WAYS-1:0]                present,
  output logic [WAYS-1:0]                match
);

  localparam logic [STATE_W-1:0] ST_I = STATE_W'(SPX_I);

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    logic [WORDS-1:0] word_valid;

    for (genvar j = 0; j < WORDS; j++) begin : g_word
      assign word_valid[j] = states[(i*WORDS+j)*STATE_W +: STATE_W] > ST_I;
    end

    // A stale tag left in an empty way must never count as a hit.
    assign present[i] = |word_valid;
    assign match[i]   = present[i] && (tags[i*TAG_W +: TAG_W] == tag);
  end

endmodule

// File: rtl/l2_lookup_pipe.sv
// One-deep valid/ready lookup stage: resolves hit, empty and victim ways
// for a set snapshot and registers the result with per-word state masks.
module l2_lookup_pipe
  import l2_lookup_pkg::*;
#(
  parameter int WAYS    = 8,
  parameter int WORDS   = 4,
  parameter int TAG_W   = 20,
  parameter int STATE_W = 3,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_mode,
  input  logic [TAG_W-1:0]               in_tag,
  input  logic [WORDS-1:0]               in_word_mask,
  input  logic [WAYS*TAG_W-1:0]          in_tags,
  input  logic [WAYS*WORDS*STATE_W-1:0]  in_states,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_mode,
  output logic                           tag_hit,
  output logic [WAY_W-1:0]               way_hit,
  output logic                           multi_hit,
  output logic                           empty_way_found,
  output logic [WAY_W-1:0]               empty_way,
  output logic [WAY_W-1:0]               evict_way,
  output logic [WORDS-1:0]               word_mask_shared,
  output logic [WORDS-1:0]               word_mask_owned,
  output logic [WORDS-1:0]               word_mask_owned_evict,
  output logic [WORDS-1:0]               word_hit_mask,
  output logic                           word_hit_all,
  output logic [STATE_W-1:0]             word_hit_state
);

  localparam int LINE_W = WORDS*STATE_W;
  localparam logic [STATE_W-1:0] ST_I     = STATE_W'(SPX_I);
  localparam logic [STATE_W-1:0] ST_S     = STATE_W'(SPX_S);
  localparam logic [STATE_W-1:0] ST_R     = STATE_W'(SPX_R);
  localparam logic [WAYS-1:0]    WAYS_ONE = WAYS'(1);
  localparam logic [WAY_W-1:0]   PTR_ONE  = WAY_W'(1);

  function automatic logic [STATE_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                 input int j);
    return line[j*STATE_W +: STATE_W];
  endfunction

  logic [WAYS-1:0]   present;
  logic [WAYS-1:0]   match;
  logic [WAY_W-1:0]  rr_ptr;
  logic              accept;

  logic              hit_n;
  logic [WAY_W-1:0]  hit_way_n;
  logic [LINE_W-1:0] hit_line;
  logic              multi_n;
  logic              empty_n;
  logic [WAY_W-1:0]  empty_way_n;
  logic [LINE_W-1:0] evict_line;
  logic              evict_n;
  logic [WORDS-1:0]  shared_n;
  logic [WORDS-1:0]  owned_n;
  logic [WORDS-1:0]  owned_evict_n;
  logic [WORDS-1:0]  hit_valid_n;
  logic [WORDS-1:0]  hit_mask_n;
  logic              hit_all_n;
  logic [STATE_W-1:0] hit_state_n;

  l2_lookup_way_scan #(
    .WAYS    (WAYS),
    .WORDS   (WORDS),
    .TAG_W   (TAG_W),
    .STATE_W (STATE_W)
  ) u_scan (
    .tag     (in_tag),
    .tags    (in_tags),
    .states  (in_states),
    .present (present),
    .match   (match)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Descending scans: the last assignment wins, so the lowest index is kept.
  always_comb begin
    hit_n       = 1'b0;
    hit_way_n   = '0;
    hit_line    = '0;
    empty_n     = 1'b0;
    empty_way_n = '0;
    evict_line  = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (match[i]) begin
        hit_n     = 1'b1;
        hit_way_n = WAY_W'(i);
        hit_line  = in_states[i*LINE_W +: LINE_W];
      end
      if (!present[i] && in_mode == L2_LOOKUP) begin
        empty_n     = 1'b1;
        empty_way_n = WAY_W'(i);
      end
      if (WAY_W'(i) == rr_ptr) begin
        evict_line = in_states[i*LINE_W +: LINE_W];
      end
    end
  end

  assign multi_n = |(match & (match - WAYS_ONE));
  assign evict_n = (in_mode == L2_LOOKUP) && !hit_n && !empty_n;

  always_comb begin
    shared_n      = '0;
    owned_n       = '0;
    owned_evict_n = '0;
    hit_valid_n   = '0;
    for (int j = 0; j < WORDS; j++) begin
      owned_n[j]       = hit_n && (word_of(hit_line, j) == ST_R);
      shared_n[j]      = hit_n && (word_of(hit_line, j) == ST_R ||
                                   word_of(hit_line, j) == ST_S);
      hit_valid_n[j]   = hit_n && (word_of(hit_line, j) > ST_I);
      owned_evict_n[j] = evict_n && (word_of(evict_line, j) == ST_R);
    end
  end

  assign hit_mask_n = in_word_mask & hit_valid_n;
  assign hit_all_n  = hit_n && (hit_mask_n == in_word_mask) && (|in_word_mask);

  always_comb begin
    hit_state_n = ST_I;
    for (int j = WORDS-1; j >= 0; j--) begin
      if (hit_mask_n[j]) begin
        hit_state_n = word_of(hit_line, j);
      end
    end
  end

  // Victim pointer advances only when a REQ actually needs a victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && evict_n) begin
      rr_ptr <= rr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_mode              <= 1'b0;
      tag_hit               <= 1'b0;
      way_hit               <= '0;
      multi_hit             <= 1'b0;
      empty_way_found       <= 1'b0;
      empty_way             <= '0;
      evict_way             <= '0;
      word_mask_shared      <= '0;
      word_mask_owned       <= '0;
      word_mask_owned_evict <= '0;
      word_hit_mask         <= '0;
      word_hit_all          <= 1'b0;
      word_hit_state        <= ST_I;
    end else if (accept) begin
      out_mode              <= in_mode;
      tag_hit               <= hit_n;
      way_hit               <= hit_way_n;
      multi_hit             <= multi_n;
      empty_way_found       <= empty_n;
      empty_way             <= empty_way_n;
      evict_way             <= rr_ptr;
      word_mask_shared      <= shared_n;
      word_mask_owned       <= owned_n;
      word_mask_owned_evict <= owned_evict_n;
      word_hit_mask         <= hit_mask_n;
      word_hit_all          <= hit_all_n;
      word_hit_state        <= hit_state_n;
    end
  end

endmodule

// File: tb/tb_l2_lookup_pipe.sv
// Scoreboard bench for l2_lookup_pipe: directed snapshots with hand-worked
// expected results queued at issue and compared by a separate monitor.
module tb_l2_lookup_pipe;
  import l2_lookup_pkg::*;

  localparam int WAYS    = 8;
  localparam int WORDS   = 4;
  localparam int TAG_W   = 20;
  localparam int STATE_W = 3;

  localparam logic [TAG_W-1:0] TAG_A = 20'hABCDE;
  localparam logic [TAG_W-1:0] TAG_B = 20'h5A5A5;

  logic clk, rst;
  logic in_valid, in_ready, in_mode;
  logic [TAG_W-1:0] in_tag;
  logic [WORDS-1:0] in_word_mask;
  logic [WAYS*TAG_W-1:0] in_tags;
  logic [WAYS*WORDS*STATE_W-1:0] in_states;
  logic out_valid, out_ready, out_mode;
  logic tag_hit, multi_hit, empty_way_found, word_hit_all;
  logic [2:0] way_hit, empty_way, evict_way;
  logic [WORDS-1:0] word_mask_shared, word_mask_owned, word_mask_owned_evict, word_hit_mask;
  logic [STATE_W-1:0] word_hit_state;

  typedef struct packed {
    logic       mode;
    logic       hit;
    logic [2:0] way;
    logic       multi;
    logic       ef;
    logic [2:0] ew;
    logic [2:0] ev;
    logic [3:0] sh;
    logic [3:0] ow;
    logic [3:0] oe;
    logic [3:0] whm;
    logic       wha;
    logic [2:0] whs;
  } res_t;

  typedef struct packed {
    res_t r;
    logic chk_ev;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int results = 0;

  logic [TAG_W-1:0]   tg[WAYS];
  logic [STATE_W-1:0] st[WAYS][WORDS];

  l2_lookup_pipe #(
    .WAYS(WAYS), .WORDS(WORDS), .TAG_W(TAG_W), .STATE_W(STATE_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_tag(in_tag), .in_word_mask(in_word_mask),
    .in_tags(in_tags), .in_states(in_states),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .tag_hit(tag_hit), .way_hit(way_hit), .multi_hit(multi_hit),
    .empty_way_found(empty_way_found), .empty_way(empty_way),
    .evict_way(evict_way),
    .word_mask_shared(word_mask_shared), .word_mask_owned(word_mask_owned),
    .word_mask_owned_evict(word_mask_owned_evict),
    .word_hit_mask(word_hit_mask), .word_hit_all(word_hit_all),
    .word_hit_state(word_hit_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t mk(input logic mode, input logic hit, input logic [2:0] way,
                              input logic multi, input logic ef, input logic [2:0] ew,
                              input logic [2:0] ev, input logic [3:0] sh, input logic [3:0] ow,
                              input logic [3:0] oe, input logic [3:0] whm, input logic wha,
                              input logic [2:0] whs);
    return {mode, hit, way, multi, ef, ew, ev, sh, ow, oe, whm, wha, whs};
  endfunction

  function automatic res_t dutRes();
    return {out_mode, tag_hit, way_hit, multi_hit, empty_way_found, empty_way, evict_way,
            word_mask_shared, word_mask_owned, word_mask_owned_evict, word_hit_mask,
            word_hit_all, word_hit_state};
  endfunction

  // Fields with no defined value for this result take the expected value.
  function automatic res_t dontCare(input res_t got, input exp_t e);
    res_t g = got;
    if (!e.chk_ev) g.ev = e.r.ev;
    if (!e.r.hit) g.way = e.r.way;
    if (!e.r.ef && e.r.mode == L2_LOOKUP) g.ew = e.r.ew;
    return g;
  endfunction

  task automatic checkOutput(input string name, input res_t got, input res_t want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s got=%h want=%h", name, got, want);
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s got=%b want=%b", name, got, want);
  endtask

  // Monitor: pops one expected result per consumed output beat.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_result got=%h want=none", dutRes());
      end else begin
        mon_e = sb.pop_front();
        checkOutput($sformatf("result%0d", results), dontCare(dutRes(), mon_e), mon_e.r);
        results++;
      end
    end
  end

  task automatic clearSnap();
    for (int i = 0; i < WAYS; i++) begin
      tg[i] = '0;
      for (int j = 0; j < WORDS; j++) st[i][j] = SPX_I;
    end
  endtask

  task automatic snapMulti();
    clearSnap();
    for (int i = 0; i < 3; i++) begin
      tg[i] = 20'h11110 + TAG_W'(i);
      st[i][0] = SPX_S;
    end
    tg[3] = TAG_A; st[3][1] = SPX_S;
    tg[5] = TAG_A; st[5][2] = SPX_S;
  endtask

  task automatic snapWords();
    clearSnap();
    tg[0] = 20'h22220; st[0][3] = SPX_R;
    tg[1] = 20'h22221; st[1][0] = SPX_S;
    tg[2] = TAG_B;
    st[2][0] = SPX_R; st[2][1] = SPX_S; st[2][2] = SPX_I; st[2][3] = SPX_R;
    tg[6] = TAG_B;
  endtask

  task automatic snapFull();
    for (int i = 0; i < WAYS; i++) begin
      tg[i] = 20'h30000 + TAG_W'(i);
      st[i][0] = SPX_R; st[i][1] = SPX_I; st[i][2] = SPX_R; st[i][3] = SPX_S;
    end
  endtask

  task automatic driveSnap(input logic mode, input logic [TAG_W-1:0] tag,
                           input logic [3:0] mask);
    in_mode = mode;
    in_tag = tag;
    in_word_mask = mask;
    for (int i = 0; i < WAYS; i++) begin
      in_tags[i*TAG_W +: TAG_W] = tg[i];
      for (int j = 0; j < WORDS; j++)
        in_states[(i*WORDS+j)*STATE_W +: STATE_W] = st[i][j];
    end
  endtask

  // Issues one request and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic mode, input logic [TAG_W-1:0] tag,
                               input logic [3:0] mask, input res_t want, input logic chk_ev);
    exp_t e;
    logic rdy;
    int n = 0;
    driveSnap(mode, tag, mask);
    in_valid = 1'b1;
    e.r = want;
    e.chk_ev = chk_ev;
    sb.push_back(e);
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      checks++;
      $display("[TB] FAIL accept_timeout got=in_ready_low want=accepted");
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  res_t expA, expMiss, expFwdMiss;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    clearSnap();
    driveSnap(L2_LOOKUP, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    checkBit("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_outputs", dutRes(), '0);
    rst = 1'b0;

    // Multi-hit with lowest hit way 3 and first empty way 4.
    snapMulti();
    applyStimulus(L2_LOOKUP, TAG_A, 4'b0010,
                  mk(L2_LOOKUP, 1, 3'd3, 1, 1, 3'd4, 0, 4'b0010, 4'b0000, 4'b0000,
                     4'b0010, 1, SPX_S), 0);

    // Word masks on hit way 2 with states R,S,I,R; stale tag in empty way 6.
    snapWords();
    expA = mk(L2_LOOKUP, 1, 3'd2, 0, 1, 3'd3, 0, 4'b1011, 4'b1001, 4'b0000,
              4'b0010, 0, SPX_S);
    applyStimulus(L2_LOOKUP, TAG_B, 4'b0110, expA, 0);
    applyStimulus(L2_LOOKUP, TAG_B, 4'b1001,
                  mk(L2_LOOKUP, 1, 3'd2, 0, 1, 3'd3, 0, 4'b1011, 4'b1001, 4'b0000,
                     4'b1001, 1, SPX_R), 0);
    applyStimulus(L2_LOOKUP, TAG_B, 4'b0000,
                  mk(L2_LOOKUP, 1, 3'd2, 0, 1, 3'd3, 0, 4'b1011, 4'b1001, 4'b0000,
                     4'b0000, 0, SPX_I), 0);
    applyStimulus(L2_LOOKUP, TAG_B, 4'b1111,
                  mk(L2_LOOKUP, 1, 3'd2, 0, 1, 3'd3, 0, 4'b1011, 4'b1001, 4'b0000,
                     4'b1011, 0, SPX_R), 0);
    applyStimulus(L2_LOOKUP_FWD, TAG_B, 4'b0110,
                  mk(L2_LOOKUP_FWD, 1, 3'd2, 0, 0, 3'd0, 0, 4'b1011, 4'b1001, 4'b0000,
                     4'b0010, 0, SPX_S), 0);

    // Nine back-to-back misses walk the victim pointer 0..7 then wrap to 0.
    snapFull();
    for (int k = 0; k < 9; k++) begin
      expMiss = mk(L2_LOOKUP, 0, 3'd0, 0, 0, 3'd0, 3'(k % 8), 4'b0000, 4'b0000,
                   4'b0101, 4'b0000, 0, SPX_I);
      applyStimulus(L2_LOOKUP, TAG_A, 4'b1111, expMiss, 1);
    end

    // FWD misses and a REQ hit must leave the pointer where it was (now 1).
    expFwdMiss = mk(L2_LOOKUP_FWD, 0, 3'd0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000,
                    4'b0000, 4'b0000, 0, SPX_I);
    applyStimulus(L2_LOOKUP_FWD, TAG_A, 4'b1111, expFwdMiss, 0);
    applyStimulus(L2_LOOKUP, TAG_A, 4'b1111,
                  mk(L2_LOOKUP, 0, 3'd0, 0, 0, 3'd0, 3'd1, 0, 0, 4'b0101, 0, 0, SPX_I), 1);
    applyStimulus(L2_LOOKUP_FWD, TAG_A, 4'b0001, expFwdMiss, 0);
    applyStimulus(L2_LOOKUP, TAG_A, 4'b0001,
                  mk(L2_LOOKUP, 0, 3'd0, 0, 0, 3'd0, 3'd2, 0, 0, 4'b0101, 0, 0, SPX_I), 1);
    snapWords();
    applyStimulus(L2_LOOKUP, TAG_B, 4'b0110, expA, 0);
    snapFull();
    applyStimulus(L2_LOOKUP, TAG_A, 4'b0001,
                  mk(L2_LOOKUP, 0, 3'd0, 0, 0, 3'd0, 3'd3, 0, 0, 4'b0101, 0, 0, SPX_I), 1);
    idleCycles(2);

    // Stall: result A held for three cycles while request B waits.
    out_ready = 1'b0;
    snapWords();
    applyStimulus(L2_LOOKUP, TAG_B, 4'b0110, expA, 0);
    snapFull();
    expMiss = mk(L2_LOOKUP, 0, 3'd0, 0, 0, 3'd0, 3'd4, 0, 0, 4'b0101, 0, 0, SPX_I);
    applyStimulus_noWait(expMiss);
    repeat (3) begin
      @(negedge clk);
      checkBit("stall_in_ready", in_ready, 1'b0);
      checkOutput("stall_hold", dontCare(dutRes(), '{r: expA, chk_ev: 1'b0}), expA);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkBit("release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkBit("release_b_valid", out_valid, 1'b1);
    idleCycles(2);

    // Reset during a stall drops the held result and the pointer.
    out_ready = 1'b0;
    snapMulti();
    applyStimulus(L2_LOOKUP, TAG_A, 4'b0010,
                  mk(L2_LOOKUP, 1, 3'd3, 1, 1, 3'd4, 0, 4'b0010, 0, 0, 4'b0010, 1, SPX_S), 0);
    in_valid = 1'b1;
    @(negedge clk);
    checkBit("pre_reset_valid", out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkBit("mid_reset_out_valid", out_valid, 1'b0);
    checkOutput("mid_reset_outputs", dutRes(), '0);
    checkBit("mid_reset_in_ready", in_ready, 1'b1);
    sb.delete();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    snapFull();
    applyStimulus(L2_LOOKUP, TAG_A, 4'b1111,
                  mk(L2_LOOKUP, 0, 3'd0, 0, 0, 3'd0, 3'd0, 0, 0, 4'b0101, 0, 0, SPX_I), 1);
    idleCycles(4);

    checks++;
    if (sb.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard_drain got=%0d want=0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Presents request B during a stall without waiting for it to be accepted.
  task automatic applyStimulus_noWait(input res_t want);
    exp_t e;
    driveSnap(L2_LOOKUP, TAG_A, 4'b1111);
    in_valid = 1'b1;
    e.r = want;
    e.chk_ev = 1'b1;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
